// File: rtl/gardner_sampler_if.sv
// Sample-in / symbol-out bundle for the Gardner timing-recovery sampler.
interface gardner_sampler_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 16
);
  logic                    in_valid;
  logic                    open_loop;
  logic [3:0]              GARDNER_SHIFT;
  logic signed [WIDTH-1:0] I_in;
  logic signed [WIDTH-1:0] Q_in;
  logic signed [WIDTH-1:0] error_n;
  logic signed [WIDTH-1:0] sym_I;
  logic signed [WIDTH-1:0] sym_Q;
  logic signed [WIDTH-1:0] mid_I;
  logic signed [WIDTH-1:0] mid_Q;
  logic                    sym_valid;
  logic signed [ACC_W-1:0] adj;

  modport master (
    output in_valid, open_loop, GARDNER_SHIFT, I_in, Q_in, error_n,
    input  sym_I, sym_Q, mid_I, mid_Q, sym_valid, adj
  );
  modport slave (
    input  in_valid, open_loop, GARDNER_SHIFT, I_in, Q_in, error_n,
    output sym_I, sym_Q, mid_I, mid_Q, sym_valid, adj
  );
endinterface

// File: rtl/gardner_sampler.sv
// Phase-accumulator symbol sampler: picks on-time and mid-symbol I/Q samples,
// steering the symbol rate with a clamped, shifted timing error per symbol.
module gardner_sampler #(
  parameter int WIDTH    = 16,
  parameter int ACC_W    = 16,
  parameter int OSR_LOG2 = 5,
  parameter int ADJ_MAX  = 512
) (
  input logic              clk,
  input logic              rst_n,
  gardner_sampler_if.slave bus
);
  localparam int CW = ((WIDTH > ACC_W) ? WIDTH : ACC_W) + 1;
  localparam logic [ACC_W:0] NOM =
    {{OSR_LOG2{1'b0}}, 1'b1, {(ACC_W-OSR_LOG2){1'b0}}};
  localparam logic signed [CW-1:0] ADJ_HI = CW'(ADJ_MAX);
  localparam logic signed [CW-1:0] ADJ_LO = -ADJ_HI;

  logic [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0] adj_q;
  logic signed [WIDTH-1:0] mid_i_q, mid_q_q;
  logic [ACC_W:0]          step, sum;
  logic                    carry, mid_stb;
  logic signed [WIDTH-1:0] err_sh;
  logic signed [CW-1:0]    err_ext, err_clamp;
  logic signed [ACC_W-1:0] adj_nxt;

  // step stays positive because ADJ_MAX <= NOM/2, so the ACC_W+1 bit sum never wraps
  always_comb begin
    step    = NOM + {adj_q[ACC_W-1], adj_q};
    sum     = {1'b0, acc} + step;
    carry   = sum[ACC_W];
    mid_stb = !acc[ACC_W-1] && sum[ACC_W-1] && !carry;
  end

  // widen before clamping so the most negative error cannot overflow
  always_comb begin
    err_sh  = bus.error_n >>> bus.GARDNER_SHIFT;
    err_ext = {{(CW-WIDTH){err_sh[WIDTH-1]}}, err_sh};
    if (err_ext > ADJ_HI)      err_clamp = ADJ_HI;
    else if (err_ext < ADJ_LO) err_clamp = ADJ_LO;
    else                       err_clamp = err_ext;
    adj_nxt = bus.open_loop ? '0 : ACC_W'(err_clamp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      adj_q         <= '0;
      mid_i_q       <= '0;
      mid_q_q       <= '0;
      bus.sym_I     <= '0;
      bus.sym_Q     <= '0;
      bus.mid_I     <= '0;
      bus.mid_Q     <= '0;
      bus.sym_valid <= 1'b0;
    end else begin
      bus.sym_valid <= 1'b0;
      if (bus.in_valid) begin
        acc <= sum[ACC_W-1:0];
        if (mid_stb) begin
          mid_i_q <= bus.I_in;
          mid_q_q <= bus.Q_in;
        end
        if (carry) begin
          bus.sym_I     <= bus.I_in;
          bus.sym_Q     <= bus.Q_in;
          bus.mid_I     <= mid_i_q;
          bus.mid_Q     <= mid_q_q;
          bus.sym_valid <= 1'b1;
          adj_q         <= adj_nxt;
        end
      end
    end
  end

  assign bus.adj = adj_q;
endmodule

// File: tb/tb_gardner_sampler.sv
// Randomized bench for gardner_sampler against a phase-arithmetic reference model.
module tb_gardner_sampler;
  localparam int WIDTH = 16;
  localparam int ACC_W = 16;
  localparam int ONE   = 65536;
  localparam int HALF  = 32768;
  localparam int NOM   = 2048;
  localparam int AMAX  = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gardner_sampler_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();
  gardner_sampler #(.WIDTH(WIDTH), .ACC_W(ACC_W), .OSR_LOG2(5), .ADJ_MAX(AMAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference state: phase in units where one symbol = ONE
  int m_acc, m_adj, m_mi, m_mq, m_si, m_sq, m_oi, m_oq;
  bit m_sv;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_acc = 0; m_adj = 0; m_mi = 0; m_mq = 0;
    m_si = 0; m_sq = 0; m_oi = 0; m_oq = 0; m_sv = 0;
  endtask

  task automatic model_step(input bit iv, input bit ol, input int sh,
                            input int i, input int q, input int e);
    int nxt, a;
    m_sv = 0;
    if (!iv) return;
    nxt = m_acc + NOM + m_adj;
    if (nxt >= ONE) begin
      m_si = i; m_sq = q; m_oi = m_mi; m_oq = m_mq; m_sv = 1;
      a = e >>> sh;
      if (a > AMAX) a = AMAX;
      if (a < -AMAX) a = -AMAX;
      m_adj = ol ? 0 : a;
    end else if (m_acc < HALF && nxt >= HALF) begin
      m_mi = i; m_mq = q;
    end
    m_acc = nxt % ONE;
  endtask

  task automatic check_all();
    chk("sym_valid", bus.sym_valid, m_sv);
    chk("adj", bus.adj, m_adj);
    if (m_sv) begin
      chk("sym_I", bus.sym_I, m_si);
      chk("sym_Q", bus.sym_Q, m_sq);
      chk("mid_I", bus.mid_I, m_oi);
      chk("mid_Q", bus.mid_Q, m_oq);
    end
  endtask

  // one clock: drive, step the model on the edge, sample 1 ns later
  task automatic cyc(input bit iv, input bit ol, input int sh,
                     input int i, input int q, input int e);
    logic signed [15:0] i16, q16, e16;
    i16 = i[15:0]; q16 = q[15:0]; e16 = e[15:0];
    bus.in_valid = iv; bus.open_loop = ol; bus.GARDNER_SHIFT = sh[3:0];
    bus.I_in = i16; bus.Q_in = q16; bus.error_n = e16;
    @(posedge clk);
    model_step(iv, ol, sh, int'(i16), int'(q16), int'(e16));
    #1;
    check_all();
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic run_rand(input int n, input bit ol, input int sh, input int e);
    for (int k = 0; k < n; k++) cyc(1'b1, ol, sh, rnd16(), rnd16(), e);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_sv"}, bus.sym_valid, 0);
    chk({tag, "_adj"}, bus.adj, 0);
    chk({tag, "_symI"}, bus.sym_I, 0);
    chk({tag, "_symQ"}, bus.sym_Q, 0);
    chk({tag, "_midI"}, bus.mid_I, 0);
    chk({tag, "_midQ"}, bus.mid_Q, 0);
  endtask

  initial begin
    bus.in_valid = 0; bus.open_loop = 0; bus.GARDNER_SHIFT = 0;
    bus.I_in = 0; bus.Q_in = 0; bus.error_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 zero_outputs("reset");
    #2 rst_n = 1'b1;

    // ramp: strobes every 32 cycles, sample picks checked by constant too
    for (int k = 0; k < 80; k++) begin
      cyc(1'b1, 1'b0, 0, k, -k, 0);
      if (k == 30) chk("pre_first_sv", bus.sym_valid, 0);
      if (k == 31) begin
        chk("first_sym_I", bus.sym_I, 31);
        chk("first_mid_I", bus.mid_I, 15);
      end
      if (k == 63) begin
        chk("second_sym_I", bus.sym_I, 63);
        chk("second_mid_I", bus.mid_I, 47);
      end
    end

    // positive error saturates to +ADJ_MAX
    run_rand(200, 1'b0, 0, 2048);
    chk("adj_pos_sat", bus.adj, 512);
    // most negative error, shift 0
    run_rand(200, 1'b0, 0, -32768);
    chk("adj_neg_sat", bus.adj, -512);
    run_rand(120, 1'b1, 0, -32768);
    chk("adj_open_loop", bus.adj, 0);
    // shifted errors, and error changing between strobes
    run_rand(100, 1'b0, 2, 256);
    chk("adj_shift_pos", bus.adj, 64);
    run_rand(100, 1'b0, 2, -256);
    chk("adj_shift_neg", bus.adj, -64);
    for (int k = 0; k < 200; k++) cyc(1'b1, 1'b0, 2, rnd16(), rnd16(), rnd16());

    // in_valid toggling
    for (int k = 0; k < 200; k++) cyc(k[0] == 1'b0, 1'b0, 0, rnd16(), rnd16(), 0);

    // fully random
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          int'($urandom_range(0, 15)), rnd16(), rnd16(), rnd16());

    // async reset at roughly half a symbol
    rst_n = 1'b0; #2 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, 0, k, k, 0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 0, rnd16(), rnd16(), 0);
    #2 rst_n = 1'b0;
    #1 zero_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 1'b0, 0, 100 + k, 0, 0);
      if (k == 30) chk("post_rst_early", bus.sym_valid, 0);
    end
    chk("post_rst_strobe", bus.sym_valid, 1);
    chk("post_rst_sym_I", bus.sym_I, 131);
    chk("post_rst_mid_I", bus.mid_I, 115);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gardner_sampler.md
GARDNER_SAMPLER -- requirements
Module: gardner_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, I/Q sample and error width.
REQ-002 SHALL have parameter ACC_W, default 16, phase accumulator width; one symbol = 2^ACC_W phase units.
REQ-003 SHALL have parameter OSR_LOG2, default 5, log2 nominal samples per symbol; legal range 2..ACC_W-3.
REQ-004 SHALL have parameter ADJ_MAX, default 512, symmetric clamp on per-symbol step correction; legal range 0..2^(ACC_W-OSR_LOG2-1).
REQ-005 clk  in  1  sample clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input sample qualifier; state advances only when high.
REQ-008 open_loop  in  1  1 = ignore error_n, run at nominal rate.
REQ-009 GARDNER_SHIFT  in  4  arithmetic right shift applied to error_n.
REQ-010 I_in, Q_in  in  WIDTH each  signed input samples.
REQ-011 error_n  in  WIDTH  signed negated timing error from downstream TED.
REQ-012 sym_I, sym_Q  out  WIDTH each  signed on-time symbol samples.
REQ-013 mid_I, mid_Q  out  WIDTH each  signed mid-symbol samples preceding sym_I/sym_Q.
REQ-014 sym_valid  out  1  one-cycle pulse, sym_*/mid_* updated this cycle.
REQ-015 adj  out  ACC_W  signed step correction currently applied.

Function
REQ-016 Nominal step SHALL be NOM = 2^(ACC_W-OSR_LOG2); applied step SHALL be NOM + adj, computed in ACC_W+1 bits.
REQ-017 On each clk with in_valid=1, acc SHALL become (acc + step) mod 2^ACC_W; with in_valid=0, acc, adj, outputs except sym_valid SHALL hold, and sym_valid SHALL be 0 next cycle.
REQ-018 A symbol strobe SHALL occur on an in_valid cycle where acc + step >= 2^ACC_W (carry out).
REQ-019 A mid strobe SHALL occur on an in_valid cycle where acc MSB is 0 and (acc + step) MSB is 1 without carry.
REQ-020 Symbol and mid strobes SHALL never coincide; guaranteed by ADJ_MAX/OSR_LOG2 legal ranges.
REQ-021 On mid strobe, I_in/Q_in SHALL be captured into an internal mid register (not visible on outputs).
REQ-022 On symbol strobe, next cycle: sym_I/sym_Q = I_in/Q_in of the strobe cycle, mid_I/mid_Q = internal mid register, sym_valid = 1; latency exactly 1 cycle.
REQ-023 sym_valid SHALL be 0 on every cycle not following a symbol strobe.
REQ-024 On symbol strobe, adj SHALL update to clamp(error_n >>> GARDNER_SHIFT, -ADJ_MAX, +ADJ_MAX), sign-extended to ACC_W, or to 0 when open_loop=1; new adj affects step from the next in_valid cycle.
REQ-025 adj SHALL NOT change on any non-strobe cycle; error_n is sampled only on symbol strobe cycles.
REQ-026 Shift SHALL be arithmetic (sign-preserving); error_n = most negative value with shift 0 SHALL clamp to -ADJ_MAX without overflow.
REQ-027 Missing mid strobe before a symbol strobe (impossible in legal configs) SHALL leave mid register at its previous value.

Reset
REQ-028 rst_n low SHALL asynchronously clear acc, adj, mid register, sym_I, sym_Q, mid_I, mid_Q, sym_valid to 0, at any time including mid-symbol.
REQ-029 After rst_n deasserts, first symbol strobe SHALL occur on the 2^OSR_LOG2-th in_valid cycle when error_n/adj stay 0.

Verification (WIDTH=16, ACC_W=16, OSR_LOG2=5, ADJ_MAX=512, NOM=2048)
REQ-030 Reset release, in_valid=1, error_n=0, I_in=ramp 0,1,2,... -> sym_valid pulses every 32 cycles; first sym_I=31, mid_I=15; second sym_I=63, mid_I=47.
REQ-031 error_n=+2048, shift=0, closed loop -> adj=+512 after first strobe, step 2560, symbol spacing alternates 25/26 cycles (mean 25.6).
REQ-032 error_n=-32768, shift=0 -> adj=-512, no overflow, spacing 42/43 (mean 42.67); same with open_loop=1 -> adj=0, spacing 32.
REQ-033 error_n=+256, shift=2 -> adj=+64; error_n=-256, shift=2 -> adj=-64; error_n changing between strobes -> adj unchanged until next strobe.
REQ-034 in_valid toggled 1,0,1,0 -> strobes occur every 64 clocks, sampled values only from in_valid cycles, sym_valid never during in_valid=0 hold.
REQ-035 rst_n pulsed low at acc≈half symbol -> all outputs 0 immediately; next strobe on 32nd in_valid cycle after release.
